hazard_scoreboard: RTL and testbench

Parametrised scoreboard-based hazard unit for the RISC-V pipeline. It replaces fixed load-use detection with a per-register countdown of cycles until each pending result can be forwarded, so variable-latency producers (load, multi-cycle multiply) stall dependent instructions for exactly the required number of cycles. It sits beside the datapath at the decode/execute boundary and drives the fetch/decode stall and flush controls. Forward-select generation stays in the existing forwarding logic.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard_sb_entry.sv | 23 ++
 rtl/hazard_scoreboard.sv | 74 +++++++
 tb/tb_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared latency constants for the scoreboard hazard unit
package hazard_pkg;

   // Default width of the per-register latency countdown.
   localparam int LAT_W_DEF = 3;

   // Forwarding latency of each producer class, in cycles until a consumer may enter E.
   localparam logic [LAT_W_DEF-1:0] LAT_ALU  = 3'd0;
   localparam logic [LAT_W_DEF-1:0] LAT_LOAD = 3'd1;
   localparam logic [LAT_W_DEF-1:0] LAT_MUL  = 3'd3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage request and stall/flush control bundle
interface hazard_scoreboard_if #(
   parameter int REG_AW = 5,
   parameter int LAT_W  = hazard_pkg::LAT_W_DEF
);

   // Decode-stage instruction description.
   logic              validD;
   logic [REG_AW-1:0] Rs1D;
   logic [REG_AW-1:0] Rs2D;
   logic              useRs1D;
   logic              useRs2D;
   logic [REG_AW-1:0] RdD;
   logic              RegWriteD;
   logic [LAT_W-1:0]  LatD;

   // Branch resolution from execute.
   logic              PCSrcE;

   // Pipeline controls back to fetch/decode/execute.
   logic              StallF;
   logic              StallD;
   logic              FlushD;
   logic              FlushE;

   // Datapath side: presents the D instruction, receives the controls.
   modport master (
      output validD, Rs1D, Rs2D, useRs1D, useRs2D, RdD, RegWriteD, LatD, PCSrcE,
      input  StallF, StallD, FlushD, FlushE
   );

   // Scoreboard side.
   modport slave (
      input  validD, Rs1D, Rs2D, useRs1D, useRs2D, RdD, RegWriteD, LatD, PCSrcE,
      output StallF, StallD, FlushD, FlushE
   );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// rtl/hazard_scoreboard_sb_entry.sv - one register's countdown to forwardability
module sb_entry #(
   parameter int LAT_W = hazard_pkg::LAT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [LAT_W-1:0] latIn,
   output logic [LAT_W-1:0] ctr
);

   // A new producer reloads the count; otherwise count down and hold at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctr <= '0;
      end else if (load) begin
         ctr <= latIn;
      end else if (ctr != '0) begin
         ctr <= ctr - LAT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency scoreboard driving stall/flush; optional SCOREBOARD_STATS_EN stall counter
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG   = 32,
   parameter int REG_AW = 5,
   parameter int LAT_W  = LAT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   hazard_scoreboard_if.slave  hzIf
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [31:0]         stall_cycles
`endif
);

   logic [LAT_W-1:0] ctrArr [NREG];
   logic             rawHz;
   logic             wawHz;
   logic             hz;
   logic             iss;

   // x0 is hardwired, so its slot always reads as ready.
   assign ctrArr[0] = '0;

   generate
      for (genvar r = 1; r < NREG; r++) begin : gEntry
         sb_entry #(.LAT_W(LAT_W)) uEntry (
            .clk   (clk),
            .reset (reset),
            .load  (iss && (hzIf.RdD == REG_AW'(r))),
            .latIn (hzIf.LatD),
            .ctr   (ctrArr[r])
         );
      end
   endgenerate

   // Hazard detection and control outputs; a taken branch overrides any stall and records nothing.
   always_comb begin
      rawHz = 1'b0;
      wawHz = 1'b0;
      hz    = 1'b0;
      iss   = 1'b0;

      rawHz = hzIf.validD &&
              ((hzIf.useRs1D && (hzIf.Rs1D != '0) && (ctrArr[hzIf.Rs1D] != '0)) ||
               (hzIf.useRs2D && (hzIf.Rs2D != '0) && (ctrArr[hzIf.Rs2D] != '0)));

      // A later writer must not become forwardable before an older in-flight one.
      wawHz = hzIf.validD && hzIf.RegWriteD && (hzIf.RdD != '0) &&
              (ctrArr[hzIf.RdD] > hzIf.LatD);

      hz  = (rawHz || wawHz) && !hzIf.PCSrcE;
      iss = hzIf.validD && hzIf.RegWriteD && (hzIf.RdD != '0) && !hz && !hzIf.PCSrcE;

      hzIf.StallF = hz;
      hzIf.StallD = hz;
      hzIf.FlushE = hz || hzIf.PCSrcE;
      hzIf.FlushD = hzIf.PCSrcE;
   end

`ifdef SCOREBOARD_STATS_EN
   // Count every cycle the front end is held by a hazard; wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (hz) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   logic clk;
   logic reset;
   int   nCompared;
   int   nMismatched;
   int   nStall;
`ifdef SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] statsBefore;
`endif

   hazard_scoreboard_if #(.REG_AW(5), .LAT_W(3)) hzIf ();

   hazard_scoreboard #(.NREG(32), .REG_AW(5), .LAT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .hzIf  (hzIf)
`ifdef SCOREBOARD_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic setD(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic [2:0] lat);
      hzIf.validD    = v;
      hzIf.Rs1D      = rs1;
      hzIf.useRs1D   = u1;
      hzIf.Rs2D      = rs2;
      hzIf.useRs2D   = u2;
      hzIf.RdD       = rd;
      hzIf.RegWriteD = rw;
      hzIf.LatD      = lat;
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      hzIf.PCSrcE = 1'b0;
      repeat (8) stepEdge();
   endtask

   // Count stall cycles seen by the D instruction; returns once it would issue at the next edge.
   task automatic countStalls(output int n);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (!hzIf.StallD) break;
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   int expCtr   [4] = '{3, 2, 1, 0};
   int expStall [4] = '{1, 1, 1, 0};

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      reset       = 1'b1;
      hzIf.PCSrcE = 1'b0;
      setD(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, LAT_MUL);

      // Reset state: nothing pending, all controls low.
      #2;
      checkVal("rst_StallF", 32'(hzIf.StallF), 0);
      checkVal("rst_StallD", 32'(hzIf.StallD), 0);
      checkVal("rst_FlushD", 32'(hzIf.FlushD), 0);
      checkVal("rst_FlushE", 32'(hzIf.FlushE), 0);
`ifdef SCOREBOARD_STATS_EN
      checkVal("rst_stats", stall_cycles, 0);
`endif
      setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      stepEdge();

      // Load x5 then dependent add: one stall cycle.
      setD(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, LAT_LOAD);
      @(negedge clk);
      checkVal("ld_issue_nostall", 32'(hzIf.StallD), 0);
      stepEdge();
      checkVal("ld_ctr5", 32'(dut.ctrArr[5]), 1);
      setD(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, LAT_ALU);
      #1;
      checkVal("ld_use_StallF", 32'(hzIf.StallF), 1);
      checkVal("ld_use_FlushE", 32'(hzIf.FlushE), 1);
      checkVal("ld_use_FlushD", 32'(hzIf.FlushD), 0);
      countStalls(nStall);
      checkVal("ld_use_stalls", 32'(nStall), 1);
      stepEdge();
      drain();

      // ALU result forwards with no stall.
      setD(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, LAT_ALU);
      stepEdge();
      setD(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, LAT_ALU);
      countStalls(nStall);
      checkVal("alu_stalls", 32'(nStall), 0);
      stepEdge();
      drain();

      // mul x8 then add x9,x8: counter walks 3,2,1,0 with three stalls.
      setD(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, LAT_MUL);
      stepEdge();
      setD(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, LAT_ALU);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkVal($sformatf("mul_ctr8_%0d", i), 32'(dut.ctrArr[8]), 32'(expCtr[i]));
         checkVal($sformatf("mul_stall_%0d", i), 32'(hzIf.StallD), 32'(expStall[i]));
         stepEdge();
      end
      drain();

      // Taken branch overrides a RAW stall and records nothing for D.
      setD(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, LAT_MUL);
      stepEdge();
      setD(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, LAT_MUL);
      hzIf.PCSrcE = 1'b1;
      @(negedge clk);
      checkVal("br_StallD", 32'(hzIf.StallD), 0);
      checkVal("br_StallF", 32'(hzIf.StallF), 0);
      checkVal("br_FlushD", 32'(hzIf.FlushD), 1);
      checkVal("br_FlushE", 32'(hzIf.FlushE), 1);
      stepEdge();
      checkVal("br_ctr8_decayed", 32'(dut.ctrArr[8]), 2);
      drain();

      // x0 is never tracked.
      setD(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, LAT_MUL);
      stepEdge();
      setD(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, LAT_ALU);
      countStalls(nStall);
      checkVal("x0_stalls", 32'(nStall), 0);
      stepEdge();
      drain();

      // WAW: mul x7 then load x7 waits until ctr7 <= 1.
`ifdef SCOREBOARD_STATS_EN
      statsBefore = stall_cycles;
`endif
      setD(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, LAT_MUL);
      stepEdge();
      setD(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, LAT_LOAD);
      countStalls(nStall);
      checkVal("waw_stalls", 32'(nStall), 2);
      stepEdge();
      checkVal("waw_ctr7_reloaded", 32'(dut.ctrArr[7]), 1);
`ifdef SCOREBOARD_STATS_EN
      checkVal("waw_stats_delta", stall_cycles - statsBefore, 2);
`endif
      drain();

      // Asynchronous reset in the middle of a stall.
      setD(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, LAT_MUL);
      stepEdge();
      setD(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 3'd2);
      stepEdge();
      checkVal("arst_pre_ctr8", 32'(dut.ctrArr[8]), 2);
      checkVal("arst_pre_stall", 32'(hzIf.StallD), 1);
      reset = 1'b1;
      #1;
      checkVal("arst_ctr8", 32'(dut.ctrArr[8]), 0);
      checkVal("arst_StallD", 32'(hzIf.StallD), 0);
      checkVal("arst_StallF", 32'(hzIf.StallF), 0);
      checkVal("arst_FlushE", 32'(hzIf.FlushE), 0);
`ifdef SCOREBOARD_STATS_EN
      checkVal("arst_stats", stall_cycles, 0);
`endif
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkVal("arst_post_stall", 32'(hzIf.StallD), 0);
      stepEdge();
      checkVal("arst_consumer_issued", 32'(dut.ctrArr[9]), 2);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
